// File: rtl/lsu.sv
// Load-store unit for the RV32I single-cycle core.
// Decodes the effective address onto a word-addressed data memory and a small
// set of memory-mapped peripheral words, commits stores on the rising edge and
// returns sign/zero-extended load data combinationally in the same cycle.
module lsu #(
  parameter int unsigned DMEM_WORDS = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [63:0] o_io_hex
);

  localparam int unsigned AW = $clog2(DMEM_WORDS);

  // DMEM occupies [DMEM_BASE, DMEM_END); the 33-bit compare keeps the upper
  // bound from wrapping when the region reaches the top of the 32-bit space.
  localparam logic [32:0]   DMEM_BASE     = 33'h0_0000_2000;
  localparam logic [32:0]   DMEM_END      = DMEM_BASE + 33'(4 * DMEM_WORDS);
  localparam logic [AW-1:0] DMEM_BASE_IDX = AW'(32'h2000 >> 2);

  // Peripheral word addresses (byte address >> 2).
  localparam logic [29:0] LEDR_WA  = 30'h0000_1C00;
  localparam logic [29:0] LEDG_WA  = 30'h0000_1C04;
  localparam logic [29:0] HEXLO_WA = 30'h0000_1C08;
  localparam logic [29:0] HEXHI_WA = 30'h0000_1C09;
  localparam logic [29:0] SW_WA    = 30'h0000_1E00;
  localparam logic [29:0] BTN_WA   = 30'h0000_1E04;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  // Byte-lane merge: lanes selected by mask take the new data, others keep old.
  function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  mask);
    logic [31:0] result;
    result = oldWord;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        result[8*k +: 8] = newWord[8*k +: 8];
      end
    end
    return result;
  endfunction

  logic [29:0]   wordAddr;
  logic          hitDmem;
  logic          hitLedr;
  logic          hitLedg;
  logic          hitHexLo;
  logic          hitHexHi;
  logic          hitSw;
  logic          hitBtn;
  logic          hitOut;
  logic          mapped;
  logic          misaligned;
  logic [AW-1:0] dmemIdx;

  logic [3:0]    byteMask;
  logic [31:0]   wrData;
  logic          storeEn;
  logic          dmemWe;

  logic [31:0]   dmem_q [DMEM_WORDS];

  logic [31:0]   ledr_q,  ledr_d;
  logic [31:0]   ledg_q,  ledg_d;
  logic [31:0]   hexLo_q, hexLo_d;
  logic [31:0]   hexHi_q, hexHi_d;

  logic [31:0]   swMeta_q,  swSync_q;
  logic [3:0]    btnMeta_q, btnSync_q;

  logic [31:0]   readWord;
  logic [7:0]    readByte;
  logic [15:0]   readHalf;
  logic [31:0]   ldData;

  assign wordAddr = i_lsu_addr[31:2];
  assign dmemIdx  = i_lsu_addr[AW+1:2] - DMEM_BASE_IDX;

  // Full-address decode: DMEM by range, peripherals by exact word match.
  always_comb begin
    hitDmem  = ({1'b0, i_lsu_addr} >= DMEM_BASE) && ({1'b0, i_lsu_addr} < DMEM_END);
    hitLedr  = (wordAddr == LEDR_WA);
    hitLedg  = (wordAddr == LEDG_WA);
    hitHexLo = (wordAddr == HEXLO_WA);
    hitHexHi = (wordAddr == HEXHI_WA);
    hitSw    = (wordAddr == SW_WA);
    hitBtn   = (wordAddr == BTN_WA);
    hitOut   = hitLedr || hitLedg || hitHexLo || hitHexHi;
    mapped   = hitDmem || hitOut || hitSw || hitBtn;
  end

  // Alignment check depends only on access size and the low address bits.
  always_comb begin
    misaligned = 1'b0;
    case (i_funct3)
      F3_H, F3_HU: misaligned = i_lsu_addr[0];
      F3_W:        misaligned = (i_lsu_addr[1:0] != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  end

  // Store lane mask and lane-replicated write data; invalid sizes give no lanes.
  always_comb begin
    byteMask = 4'b0000;
    wrData   = i_st_data;
    case (i_funct3)
      F3_B: begin
        byteMask = 4'b0001 << i_lsu_addr[1:0];
        wrData   = {4{i_st_data[7:0]}};
      end
      F3_H: begin
        byteMask = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
        wrData   = {2{i_st_data[15:0]}};
      end
      F3_W: begin
        byteMask = 4'b1111;
        wrData   = i_st_data;
      end
      default: begin
        byteMask = 4'b0000;
        wrData   = i_st_data;
      end
    endcase
  end

  assign storeEn = i_lsu_wren && (byteMask != 4'b0000) && !misaligned && (hitDmem || hitOut);
  assign dmemWe  = storeEn && hitDmem && !i_rst;

  // Data memory: byte-lane writes, no reset so it maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (dmemWe) begin
      for (int k = 0; k < 4; k++) begin
        if (byteMask[k]) begin
          dmem_q[dmemIdx][8*k +: 8] <= wrData[8*k +: 8];
        end
      end
    end
  end

  // Next-state values for the output registers: merge lanes only on a hit.
  always_comb begin
    ledr_d  = ledr_q;
    ledg_d  = ledg_q;
    hexLo_d = hexLo_q;
    hexHi_d = hexHi_q;
    if (storeEn) begin
      if (hitLedr)  ledr_d  = mergeLanes(ledr_q,  wrData, byteMask);
      if (hitLedg)  ledg_d  = mergeLanes(ledg_q,  wrData, byteMask);
      if (hitHexLo) hexLo_d = mergeLanes(hexLo_q, wrData, byteMask);
      if (hitHexHi) hexHi_d = mergeLanes(hexHi_q, wrData, byteMask);
    end
  end

  // Output registers clear immediately on reset and load their next state otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ledr_q  <= '0;
      ledg_q  <= '0;
      hexLo_q <= '0;
      hexHi_q <= '0;
    end else begin
      ledr_q  <= ledr_d;
      ledg_q  <= ledg_d;
      hexLo_q <= hexLo_d;
      hexHi_q <= hexHi_d;
    end
  end

  // Two-flop synchronizers bring the asynchronous board inputs into i_clk.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      swMeta_q  <= '0;
      swSync_q  <= '0;
      btnMeta_q <= '0;
      btnSync_q <= '0;
    end else begin
      swMeta_q  <= i_io_sw;
      swSync_q  <= swMeta_q;
      btnMeta_q <= i_io_btn;
      btnSync_q <= btnMeta_q;
    end
  end

  // Word select for the load path; DMEM is read asynchronously.
  always_comb begin
    readWord = '0;
    if (hitDmem) begin
      readWord = dmem_q[dmemIdx];
    end else if (hitLedr) begin
      readWord = ledr_q;
    end else if (hitLedg) begin
      readWord = ledg_q;
    end else if (hitHexLo) begin
      readWord = hexLo_q;
    end else if (hitHexHi) begin
      readWord = hexHi_q;
    end else if (hitSw) begin
      readWord = swSync_q;
    end else if (hitBtn) begin
      readWord = {28'd0, btnSync_q};
    end
  end

  // Lane extraction and extension; anything unmapped, misaligned or invalid reads 0.
  always_comb begin
    readByte = readWord[7:0];
    case (i_lsu_addr[1:0])
      2'd0:    readByte = readWord[7:0];
      2'd1:    readByte = readWord[15:8];
      2'd2:    readByte = readWord[23:16];
      default: readByte = readWord[31:24];
    endcase
    readHalf = i_lsu_addr[1] ? readWord[31:16] : readWord[15:0];

    ldData = '0;
    case (i_funct3)
      F3_B:    ldData = {{24{readByte[7]}}, readByte};
      F3_BU:   ldData = {24'd0, readByte};
      F3_H:    ldData = {{16{readHalf[15]}}, readHalf};
      F3_HU:   ldData = {16'd0, readHalf};
      F3_W:    ldData = readWord;
      default: ldData = '0;
    endcase
    if (!mapped || misaligned) begin
      ldData = '0;
    end
  end

  assign o_ld_data    = ldData;
  assign o_misaligned = misaligned;
  assign o_io_ledr    = ledr_q;
  assign o_io_ledg    = ledg_q;
  assign o_io_hex     = {hexHi_q, hexLo_q};

endmodule
